// File: rtl/data_path_if.sv
// Control, memory-data and address signals between the MiniSRC control unit and the datapath.
// Rout[i]/Rin[i] are the R<i>out/R<i>in selects of the general register file.
interface data_path_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] Mdatain;
  logic [WIDTH-1:0] MAR_out;

  logic [15:0] Rout;
  logic [15:0] Rin;
  logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic        Read, IncPC;
  logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;

  modport master (
    output Mdatain, Rout, Rin,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    output Read, IncPC,
    output AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    input  MAR_out
  );

  modport slave (
    input  Mdatain, Rout, Rin,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    input  Read, IncPC,
    input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    output MAR_out
  );
endinterface

// File: rtl/data_path.sv
// MiniSRC phase-1 single-bus datapath: register file, special registers, bus mux and ALU.
// BusMuxIn*/BusMuxOut/Y_Out/MAR.q keep their architectural names for hierarchical probing.
module data_path #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         Clock,
  input  logic         Clear,
  data_path_if.slave   bus_if
);

  logic [WIDTH-1:0] r_q [16];
  logic [WIDTH-1:0] pc_q, ir_q, mdr_q, mdr_d, hi_q, lo_q, y_q;
  logic [2*WIDTH-1:0] z_q;

  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] BusMuxInR0,  BusMuxInR1,  BusMuxInR2,  BusMuxInR3;
  logic [WIDTH-1:0] BusMuxInR4,  BusMuxInR5,  BusMuxInR6,  BusMuxInR7;
  logic [WIDTH-1:0] BusMuxInR8,  BusMuxInR9,  BusMuxInR10, BusMuxInR11;
  logic [WIDTH-1:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15;
  logic [WIDTH-1:0] BusMuxInPC, BusMuxInIR, BusMuxInMDR, BusMuxInZlo, BusMuxInZhi;
  logic [WIDTH-1:0] BusMuxInHI, BusMuxInLO;
  logic [WIDTH-1:0] Y_Out;

  assign BusMuxInR0  = r_q[0];
  assign BusMuxInR1  = r_q[1];
  assign BusMuxInR2  = r_q[2];
  assign BusMuxInR3  = r_q[3];
  assign BusMuxInR4  = r_q[4];
  assign BusMuxInR5  = r_q[5];
  assign BusMuxInR6  = r_q[6];
  assign BusMuxInR7  = r_q[7];
  assign BusMuxInR8  = r_q[8];
  assign BusMuxInR9  = r_q[9];
  assign BusMuxInR10 = r_q[10];
  assign BusMuxInR11 = r_q[11];
  assign BusMuxInR12 = r_q[12];
  assign BusMuxInR13 = r_q[13];
  assign BusMuxInR14 = r_q[14];
  assign BusMuxInR15 = r_q[15];
  assign BusMuxInPC  = pc_q;
  assign BusMuxInIR  = ir_q;
  assign BusMuxInMDR = mdr_q;
  assign BusMuxInZlo = z_q[WIDTH-1:0];
  assign BusMuxInZhi = z_q[2*WIDTH-1:WIDTH];
  assign BusMuxInHI  = hi_q;
  assign BusMuxInLO  = lo_q;
  assign Y_Out       = y_q;

  logic [15:0][WIDTH-1:0] gp_in;
  assign gp_in = {BusMuxInR15, BusMuxInR14, BusMuxInR13, BusMuxInR12,
                  BusMuxInR11, BusMuxInR10, BusMuxInR9,  BusMuxInR8,
                  BusMuxInR7,  BusMuxInR6,  BusMuxInR5,  BusMuxInR4,
                  BusMuxInR3,  BusMuxInR2,  BusMuxInR1,  BusMuxInR0};

  // Lowest-priority source is written first so higher-priority selects override it.
  always_comb begin
    BusMuxOut = '0;
    if (bus_if.MDRout)   BusMuxOut = BusMuxInMDR;
    if (bus_if.PCout)    BusMuxOut = BusMuxInPC;
    if (bus_if.Zlowout)  BusMuxOut = BusMuxInZlo;
    if (bus_if.Zhighout) BusMuxOut = BusMuxInZhi;
    if (bus_if.LOout)    BusMuxOut = BusMuxInLO;
    if (bus_if.HIout)    BusMuxOut = BusMuxInHI;
    for (int i = 15; i >= 0; i--) begin
      if (bus_if.Rout[i]) BusMuxOut = gp_in[i];
    end
  end

  // ALU: A = Y, B = bus
  logic [WIDTH-1:0]   alu_a, alu_b, divisor, quot, rem;
  logic [4:0]         sh;
  logic [2*WIDTH-1:0] prod, alu_c;

  assign alu_a   = Y_Out;
  assign alu_b   = BusMuxOut;
  assign sh      = alu_b[4:0];
  assign prod    = $signed({{WIDTH{alu_a[WIDTH-1]}}, alu_a}) *
                   $signed({{WIDTH{alu_b[WIDTH-1]}}, alu_b});
  // Divisor forced to 1 on B = 0 so the divider never sees zero; that result is discarded.
  assign divisor = (alu_b == '0) ? WIDTH'(1) : alu_b;
  assign quot    = $signed(alu_a) / $signed(divisor);
  assign rem     = $signed(alu_a) % $signed(divisor);

  always_comb begin
    alu_c = '0;
    if (bus_if.IncPC)     alu_c[WIDTH-1:0] = alu_b + WIDTH'(1);
    else if (bus_if.AND)  alu_c[WIDTH-1:0] = alu_a & alu_b;
    else if (bus_if.OR)   alu_c[WIDTH-1:0] = alu_a | alu_b;
    else if (bus_if.ADD)  alu_c[WIDTH-1:0] = alu_a + alu_b;
    else if (bus_if.SUB)  alu_c[WIDTH-1:0] = alu_a - alu_b;
    else if (bus_if.MUL)  alu_c = prod;
    else if (bus_if.DIV)  alu_c = (alu_b == '0) ? {alu_a, {WIDTH{1'b0}}} : {rem, quot};
    else if (bus_if.SHR)  alu_c[WIDTH-1:0] = alu_a >> sh;
    else if (bus_if.SHRA) alu_c[WIDTH-1:0] = $signed(alu_a) >>> sh;
    else if (bus_if.SHL)  alu_c[WIDTH-1:0] = alu_a << sh;
    else if (bus_if.ROR)  alu_c[WIDTH-1:0] = (alu_a >> sh) | (alu_a << (WIDTH - 32'(sh)));
    else if (bus_if.ROL)  alu_c[WIDTH-1:0] = (alu_a << sh) | (alu_a >> (WIDTH - 32'(sh)));
    else if (bus_if.NEG)  alu_c[WIDTH-1:0] = ~alu_b + WIDTH'(1);
    else if (bus_if.NOT)  alu_c[WIDTH-1:0] = ~alu_b;
  end

  assign mdr_d = bus_if.Read ? bus_if.Mdatain : BusMuxOut;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (bus_if.Rin[i]) r_q[i] <= BusMuxOut;
      end
      if (bus_if.PCin)  pc_q  <= BusMuxOut;
      if (bus_if.IRin)  ir_q  <= BusMuxOut;
      if (bus_if.MDRin) mdr_q <= mdr_d;
      if (bus_if.HIin)  hi_q  <= BusMuxOut;
      if (bus_if.LOin)  lo_q  <= BusMuxOut;
      if (bus_if.Yin)   y_q   <= BusMuxOut;
      if (bus_if.Zin)   z_q   <= alu_c;
    end
  end

  // MAR kept in its own named scope so its contents are reachable as MAR.q.
  if (1) begin : MAR
    logic [WIDTH-1:0] q;
    always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear)            q <= '0;
      else if (bus_if.MARin) q <= BusMuxOut;
    end
  end

  assign bus_if.MAR_out = MAR.q;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: stimulus queues expected probe values, a negedge monitor
// pops and compares them against the datapath's internal registers and bus.
module tb_data_path;
  localparam int unsigned W = 32;

  localparam int OpInc  = 0;
  localparam int OpAnd  = 1;
  localparam int OpOr   = 2;
  localparam int OpAdd  = 3;
  localparam int OpSub  = 4;
  localparam int OpMul  = 5;
  localparam int OpDiv  = 6;
  localparam int OpShr  = 7;
  localparam int OpShra = 8;
  localparam int OpShl  = 9;
  localparam int OpRor  = 10;
  localparam int OpRol  = 11;
  localparam int OpNeg  = 12;
  localparam int OpNot  = 13;

  logic clk = 1'b0;
  logic clear_n;
  always #5 clk = ~clk;

  data_path_if #(.WIDTH(W)) dp ();
  data_path #(.WIDTH(W)) dut (.Clock(clk), .Clear(clear_n), .bus_if(dp.slave));

  typedef enum int {PrBus, PrR3, PrR4, PrR7, PrPC, PrIR, PrMAR, PrMarOut, PrMDR, PrY,
                    PrZlo, PrZhi, PrHI, PrLO} probe_e;
  typedef struct {
    string       name;
    probe_e      pr;
    logic [W-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [W-1:0] probe(probe_e p);
    case (p)
      PrBus:    return dut.BusMuxOut;
      PrR3:     return dut.BusMuxInR3;
      PrR4:     return dut.BusMuxInR4;
      PrR7:     return dut.BusMuxInR7;
      PrPC:     return dut.BusMuxInPC;
      PrIR:     return dut.BusMuxInIR;
      PrMAR:    return dut.MAR.q;
      PrMarOut: return dp.MAR_out;
      PrMDR:    return dut.BusMuxInMDR;
      PrY:      return dut.Y_Out;
      PrZlo:    return dut.BusMuxInZlo;
      PrZhi:    return dut.BusMuxInZhi;
      PrHI:     return dut.BusMuxInHI;
      PrLO:     return dut.BusMuxInLO;
      default:  return 'x;
    endcase
  endfunction

  task automatic expect_v(input string n, input probe_e p, input logic [W-1:0] v);
    exp_t e;
    e.name = n;
    e.pr   = p;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: everything queued before a falling edge is checked on that edge.
  initial begin
    exp_t        e;
    logic [W-1:0] got;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = probe(e.pr);
        n_checks++;
        if (got !== e.val) begin
          n_errors++;
          $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, got, e.val);
        end
      end
    end
  end

  task automatic idle();
    dp.Rout = '0;    dp.Rin = '0;
    dp.PCout = 0;    dp.Zlowout = 0; dp.Zhighout = 0; dp.MDRout = 0; dp.HIout = 0;
    dp.LOout = 0;    dp.PCin = 0;    dp.IRin = 0;     dp.MARin = 0;  dp.MDRin = 0;
    dp.Yin = 0;      dp.Zin = 0;     dp.HIin = 0;     dp.LOin = 0;   dp.Read = 0;
    dp.IncPC = 0;    dp.AND = 0;     dp.OR = 0;       dp.ADD = 0;    dp.SUB = 0;
    dp.MUL = 0;      dp.DIV = 0;     dp.SHR = 0;      dp.SHRA = 0;   dp.SHL = 0;
    dp.ROR = 0;      dp.ROL = 0;     dp.NEG = 0;      dp.NOT = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int op);
    case (op)
      OpInc:  dp.IncPC = 1;
      OpAnd:  dp.AND = 1;
      OpOr:   dp.OR = 1;
      OpAdd:  dp.ADD = 1;
      OpSub:  dp.SUB = 1;
      OpMul:  dp.MUL = 1;
      OpDiv:  dp.DIV = 1;
      OpShr:  dp.SHR = 1;
      OpShra: dp.SHRA = 1;
      OpShl:  dp.SHL = 1;
      OpRor:  dp.ROR = 1;
      OpRol:  dp.ROL = 1;
      OpNeg:  dp.NEG = 1;
      default: dp.NOT = 1;
    endcase
  endtask

  task automatic load_reg(input int idx, input logic [W-1:0] v);
    dp.Mdatain = v; dp.Read = 1; dp.MDRin = 1;
    cycle();
    dp.MDRout = 1; dp.Rin[idx] = 1;
    cycle();
  endtask

  task automatic load_y(input logic [W-1:0] v);
    dp.Mdatain = v; dp.Read = 1; dp.MDRin = 1;
    cycle();
    dp.MDRout = 1; dp.Yin = 1;
    cycle();
  endtask

  task automatic fetch(input logic [W-1:0] pc, input logic [W-1:0] instr);
    dp.PCout = 1; dp.MARin = 1; dp.IncPC = 1; dp.Zin = 1;
    expect_v("t0_bus_pc", PrBus, pc);
    cycle();
    expect_v("t0_mar", PrMAR, pc);
    expect_v("t0_mar_out", PrMarOut, pc);
    expect_v("t0_zlo", PrZlo, pc + 1);
    dp.Mdatain = instr; dp.Zlowout = 1; dp.PCin = 1; dp.Read = 1; dp.MDRin = 1;
    expect_v("t1_bus_zlo", PrBus, pc + 1);
    cycle();
    expect_v("t1_pc", PrPC, pc + 1);
    expect_v("t1_mdr", PrMDR, instr);
    dp.MDRout = 1; dp.IRin = 1;
    expect_v("t2_bus_mdr", PrBus, instr);
    cycle();
    expect_v("t2_ir", PrIR, instr);
    expect_v("idle_bus", PrBus, '0);
    settle();
  endtask

  task automatic alu_to_z(input int src, input int op);
    dp.Rout[src] = 1; set_op(op); dp.Zin = 1;
    cycle();
  endtask

  int           logic_ops [4] = '{OpAnd, OpOr, OpAdd, OpSub};
  logic [W-1:0] logic_exp [4] = '{32'h20, 32'h26, 32'h46, 32'hFFFF_FFFE};
  int           sh_ops    [7] = '{OpShr, OpShra, OpShl, OpRor, OpRol, OpNeg, OpNot};
  int           sh_src    [7] = '{5, 5, 5, 5, 5, 6, 6};
  logic [W-1:0] sh_exp    [7] = '{32'h0800_0000, 32'hF800_0000, 32'h0000_0010, 32'h1800_0000,
                                  32'h0000_0018, 32'hFFFF_FFD8, 32'hFFFF_FFD7};

  initial begin
    clear_n    = 1'b0;
    dp.Mdatain = '0;
    idle();
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    expect_v("rst_r3", PrR3, '0);
    expect_v("rst_pc", PrPC, '0);
    expect_v("rst_z", PrZlo, '0);
    expect_v("rst_bus_idle", PrBus, '0);
    settle();

    // Register loads through MDR
    dp.Mdatain = 32'h22; dp.Read = 1; dp.MDRin = 1;
    cycle();
    expect_v("mdr_load", PrMDR, 32'h22);
    dp.MDRout = 1; dp.Rin[3] = 1;
    expect_v("bus_mdr", PrBus, 32'h22);
    cycle();
    expect_v("r3_load", PrR3, 32'h22);
    load_reg(7, 32'h24);
    expect_v("r7_load", PrR7, 32'h24);
    dp.Rout[3] = 1; dp.Yin = 1;
    cycle();
    expect_v("y_load", PrY, 32'h22);
    settle();

    // Asynchronous clear between edges
    clear_n = 1'b0;
    expect_v("clr_r3", PrR3, '0);
    expect_v("clr_r7", PrR7, '0);
    expect_v("clr_y", PrY, '0);
    expect_v("clr_mdr", PrMDR, '0);
    @(negedge clk);
    #1;
    clear_n = 1'b1;
    settle();

    fetch(32'h0, 32'h2A2B_8000);
    fetch(32'h1, 32'h1234_5678);

    load_reg(3, 32'h22);
    load_reg(7, 32'h24);
    dp.Rout[3] = 1; dp.Yin = 1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      alu_to_z(7, logic_ops[k]);
      dp.Zlowout = 1; dp.Rin[4] = 1;
      cycle();
      expect_v($sformatf("logic_op%0d_r4", k), PrR4, logic_exp[k]);
    end

    load_y(32'h8000_0001);
    load_reg(5, 32'h4);
    load_reg(6, 32'h28);
    for (int k = 0; k < 7; k++) begin
      alu_to_z(sh_src[k], sh_ops[k]);
      expect_v($sformatf("shift_op%0d_zlo", k), PrZlo, sh_exp[k]);
      expect_v($sformatf("shift_op%0d_zhi", k), PrZhi, '0);
    end

    load_y(32'hFFFF_FFFE);
    load_reg(5, 32'h3);
    alu_to_z(5, OpMul);
    expect_v("mul_zhi", PrZhi, 32'hFFFF_FFFF);
    expect_v("mul_zlo", PrZlo, 32'hFFFF_FFFA);
    dp.Zhighout = 1; dp.HIin = 1;
    cycle();
    dp.Zlowout = 1; dp.LOin = 1;
    cycle();
    expect_v("mul_hi", PrHI, 32'hFFFF_FFFF);
    expect_v("mul_lo", PrLO, 32'hFFFF_FFFA);

    load_y(32'h7);
    load_reg(5, 32'hFFFF_FFFE);
    alu_to_z(5, OpDiv);
    expect_v("div_zlo", PrZlo, 32'hFFFF_FFFD);
    expect_v("div_zhi", PrZhi, 32'h1);
    dp.Zhighout = 1; dp.HIin = 1;
    cycle();
    dp.Zlowout = 1; dp.LOin = 1;
    cycle();
    expect_v("div_hi", PrHI, 32'h1);
    expect_v("div_lo", PrLO, 32'hFFFF_FFFD);

    load_reg(5, 32'h0);
    alu_to_z(5, OpDiv);
    expect_v("div0_zlo", PrZlo, '0);
    expect_v("div0_zhi", PrZhi, 32'h7);
    settle();

    // Bus priority with several selects (MDR holds 0 here, HI holds 1)
    dp.Rout[3] = 1; dp.Rout[7] = 1;
    expect_v("prio_r3_r7", PrBus, 32'h22);
    settle();
    idle();
    dp.HIout = 1; dp.MDRout = 1;
    expect_v("prio_hi_mdr", PrBus, 32'h1);
    settle();
    idle();
    dp.Rout[7] = 1; dp.HIout = 1;
    expect_v("prio_r7_hi", PrBus, 32'h24);
    settle();
    idle();

    // Op priority: ADD wins over SUB (Y = 7, B = 0x24)
    dp.Rout[7] = 1; dp.ADD = 1; dp.SUB = 1; dp.Zin = 1;
    cycle();
    expect_v("prio_add_sub", PrZlo, 32'h2B);
    // Z as both bus source and load target takes the pre-edge value
    dp.Zlowout = 1; dp.IncPC = 1; dp.Zin = 1;
    cycle();
    expect_v("z_self_inc", PrZlo, 32'h2C);
    dp.Rout[7] = 1; dp.Zin = 1;
    cycle();
    expect_v("no_op_zlo", PrZlo, '0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
